// File: rtl/gpio_pattern_gen.sv
// gpio_pattern_gen
// Configurable GPIO/LED pattern engine. A prescaler divides clk down to a
// one-cycle pattern tick. On each tick the pattern state either steps (static,
// blink, walking-one, binary count) or takes on a newly accepted configuration.
// Changes only happen on a tick, so a visible pattern never changes part way
// through a period. A 4-bit PWM counter dims the visible vector to one of 16
// levels.
//
// Ports
//   clk          fabric clock
//   rst          asynchronous, active-high reset
//   enable       high: prescaler, PWM counter and output register run; low: freeze
//   cfg_valid    configuration offered
//   cfg_ready    configuration can be accepted (no config pending)
//   cfg_mode     0 static, 1 blink, 2 walk, 3 count
//   cfg_pattern  seed / pattern value (WIDTH bits)
//   cfg_duty     PWM level 0..15 (15 = always on, 0 = on 1 of 16 cycles)
//   tick_o       one-cycle pulse per pattern tick
//   gpio_io_o    registered GPIO drive (WIDTH bits)
module gpio_pattern_gen #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 30_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [WIDTH-1:0] cfg_pattern,
    input  logic [3:0]       cfg_duty,
    output logic             tick_o,
    output logic [WIDTH-1:0] gpio_io_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    logic [PW-1:0]    presc;
    logic [3:0]       pwm_cnt;
    mode_t            mode_q;
    logic [WIDTH-1:0] state_q;
    logic             phase_q;
    logic [3:0]       duty_q;
    logic             pend_q;
    mode_t            pend_mode;
    logic [WIDTH-1:0] pend_pattern;
    logic [3:0]       pend_duty;

    logic             tick;
    logic             accept;
    logic             gate;
    logic [WIDTH-1:0] vis;

    // The tick edge is the edge at which the last prescaler count is sampled;
    // tick_o is its registered echo, visible during the following cycle.
    assign tick      = enable && (presc == PRESC_LAST);
    assign cfg_ready = !pend_q;
    assign accept    = cfg_valid && cfg_ready;
    assign gate      = (pwm_cnt <= duty_q);
    assign vis       = (mode_q == MODE_BLINK && !phase_q) ? '0 : state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc        <= '0;
            pwm_cnt      <= '0;
            mode_q       <= MODE_STATIC;
            state_q      <= '0;
            phase_q      <= 1'b1;
            duty_q       <= 4'hF;
            pend_q       <= 1'b0;
            pend_mode    <= MODE_STATIC;
            pend_pattern <= '0;
            pend_duty    <= '0;
            tick_o       <= 1'b0;
            gpio_io_o    <= '0;
        end else begin
            tick_o <= tick;

            if (enable) begin
                presc     <= tick ? '0 : presc + PW'(1);
                pwm_cnt   <= pwm_cnt + 4'd1;
                gpio_io_o <= vis & {WIDTH{gate}};
            end

            // cfg_ready is low whenever pend_q is set, so an accept can never
            // collide with the apply below that clears pend_q. An accept on a
            // tick edge sees pend_q=0 and therefore waits for the next tick.
            if (accept) begin
                pend_mode    <= mode_t'(cfg_mode);
                pend_pattern <= cfg_pattern;
                pend_duty    <= cfg_duty;
                pend_q       <= 1'b1;
            end

            if (tick) begin
                if (pend_q) begin
                    mode_q  <= pend_mode;
                    duty_q  <= pend_duty;
                    state_q <= pend_pattern;
                    phase_q <= 1'b1;
                    pend_q  <= 1'b0;
                end else begin
                    case (mode_q)
                        MODE_STATIC: state_q <= state_q;
                        MODE_BLINK:  phase_q <= !phase_q;
                        MODE_WALK:   state_q <= {state_q[WIDTH-2:0], state_q[WIDTH-1]};
                        MODE_COUNT:  state_q <= state_q + WIDTH'(1);
                        default:     state_q <= state_q;
                    endcase
                end
            end
        end
    end

endmodule
